// File: rtl/ibex_rf_write_buffer.sv
// Write-back buffer in front of the hybrid register file: queues SRAM-range writes that collide
// with operand-B reads on port B and forwards queued data. Optional: IBEX_RF_WBUF_COALESCE_EN.
module ibex_rf_write_buffer #(
  parameter int DataWidth   = 32,
  parameter int Depth       = 4,
  parameter int StarveLimit = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wb_we_i,
  input  logic [4:0]                 wb_waddr_i,
  input  logic [DataWidth-1:0]       wb_wdata_i,
  output logic                       wb_ready_o,
  input  logic                       port_b_busy_i,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o,
  input  logic [4:0]                 raddr_a_i,
  input  logic [4:0]                 raddr_b_i,
  output logic                       fwd_a_valid_o,
  output logic [DataWidth-1:0]       fwd_a_data_o,
  output logic                       fwd_b_valid_o,
  output logic [DataWidth-1:0]       fwd_b_data_o,
  output logic                       stall_req_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(StarveLimit + 1);

  logic [4:0]           q_addr [Depth];
  logic [DataWidth-1:0] q_data [Depth];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;

  logic accept, is_l1, wr_l1, wr_sram, empty, drain, pass, enqueue, coalesce;

  // Handshake: a write transfers in any cycle where wb_we_i && wb_ready_o; there is no hold
  // requirement on the producer when wb_ready_o is low. Nothing transfers while in reset.
  assign accept  = wb_we_i && wb_ready_o && rst_ni;
  assign is_l1   = (wb_waddr_i[4:2] == 3'b011);
  assign wr_l1   = accept && (wb_waddr_i != 5'd0) && is_l1;
  assign wr_sram = accept && (wb_waddr_i != 5'd0) && !is_l1;
  assign empty   = (count == '0);
  assign drain   = !wr_l1 && !empty && !port_b_busy_i;
  assign pass    = !wr_l1 && empty && wr_sram && !port_b_busy_i;
  assign enqueue = wr_sram && !pass && !coalesce;

`ifdef IBEX_RF_WBUF_COALESCE_EN
  logic          coal_hit;
  logic [PW-1:0] coal_idx;

  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < Depth; i++) begin
      if (CW'(i) < count && wb_waddr_i != 5'd0 && q_addr[rd_ptr + PW'(i)] == wb_waddr_i) begin
        coal_hit = 1'b1;
        coal_idx = rd_ptr + PW'(i);
      end
    end
  end

  // A match on the head that is leaving this cycle cannot be overwritten; it enqueues instead.
  assign coalesce   = wr_sram && !pass && coal_hit && !(drain && coal_idx == rd_ptr);
  assign wb_ready_o = (count != CW'(Depth)) || (wb_we_i && coal_hit);
`else
  assign coalesce   = 1'b0;
  assign wb_ready_o = (count != CW'(Depth));
`endif

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (wr_l1 || pass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end else if (drain) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = q_addr[rd_ptr];
      rf_wdata_o = q_data[rd_ptr];
    end
  end

  // Oldest-to-youngest scan so the last hit is the youngest entry.
  always_comb begin
    fwd_a_valid_o = 1'b0;
    fwd_a_data_o  = '0;
    fwd_b_valid_o = 1'b0;
    fwd_b_data_o  = '0;
    for (int i = 0; i < Depth; i++) begin
      if (CW'(i) < count) begin
        if (raddr_a_i != 5'd0 && q_addr[rd_ptr + PW'(i)] == raddr_a_i) begin
          fwd_a_valid_o = 1'b1;
          fwd_a_data_o  = q_data[rd_ptr + PW'(i)];
        end
        if (raddr_b_i != 5'd0 && q_addr[rd_ptr + PW'(i)] == raddr_b_i) begin
          fwd_b_valid_o = 1'b1;
          fwd_b_data_o  = q_data[rd_ptr + PW'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      for (int i = 0; i < Depth; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (enqueue) begin
        q_addr[wr_ptr] <= wb_waddr_i;
        q_data[wr_ptr] <= wb_wdata_i;
        wr_ptr         <= wr_ptr + 1'b1;
      end
`ifdef IBEX_RF_WBUF_COALESCE_EN
      if (coalesce) begin
        q_data[coal_idx] <= wb_wdata_i;
      end
`endif
      if (drain) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enqueue, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!empty && port_b_busy_i) begin
        if (starve_cnt < SW'(StarveLimit)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign stall_req_o = (starve_cnt >= SW'(StarveLimit));
  assign count_o     = count;

endmodule

// File: tb/tb_ibex_rf_write_buffer.sv
// Self-checking bench for ibex_rf_write_buffer: directed scenarios plus a randomized phase,
// with expected register-file writes held in scoreboard queues.
module tb_ibex_rf_write_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = 5 + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_we = 1'b0;
  logic [4:0]    wb_waddr = '0;
  logic [DW-1:0] wb_wdata = '0;
  logic          wb_ready;
  logic          port_b_busy = 1'b0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [4:0]    raddr_a = '0;
  logic [4:0]    raddr_b = '0;
  logic          fwd_a_valid, fwd_b_valid;
  logic [DW-1:0] fwd_a_data, fwd_b_data;
  logic          stall_req;
  logic [CW-1:0] count;

  ibex_rf_write_buffer #(.DataWidth(DW), .Depth(DEPTH), .StarveLimit(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata), .wb_ready_o(wb_ready),
    .port_b_busy_i(port_b_busy),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .fwd_a_valid_o(fwd_a_valid), .fwd_a_data_o(fwd_a_data),
    .fwd_b_valid_o(fwd_b_valid), .fwd_b_data_o(fwd_b_data),
    .stall_req_o(stall_req), .count_o(count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0] exp_q[$];     // SRAM-range writes, strict order
  logic [EW-1:0] exp_l1_q[$];  // L1-range writes, immediate
  int            starve = 0;
  bit            prev_blk = 0;
  int            exp_cnt = 0;
  logic          exp_fa_v, exp_fb_v;
  logic [DW-1:0] exp_fa_d, exp_fb_d;
  logic [EW-1:0] mon_got;

  task automatic fwd_model(input logic [4:0] ra, output logic v, output logic [DW-1:0] d);
    v = 1'b0;
    d = '0;
    if (ra != 5'd0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i][EW-1:DW] == ra) begin
          v = 1'b1;
          d = exp_q[i][DW-1:0];
        end
      end
    end
  endtask

  task automatic model_sram(input logic [4:0] a, input logic [DW-1:0] d, input logic busy);
`ifdef IBEX_RF_WBUF_COALESCE_EN
    int  m;
    bit  drn;
    m   = -1;
    drn = (exp_q.size() != 0) && !busy;
    foreach (exp_q[i]) if (exp_q[i][EW-1:DW] == a) m = i;
    if (m >= 0 && !(drn && m == 0)) exp_q[m] = {a, d};
    else exp_q.push_back({a, d});
`else
    exp_q.push_back({a, d});
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic we, input logic [4:0] a, input logic [DW-1:0] d,
                      input logic busy, input logic [4:0] ra = 5'd0, input logic [4:0] rb = 5'd0);
    @(posedge clk);
    #1;
    starve = prev_blk ? ((starve < LIMIT) ? starve + 1 : starve) : 0;
    wb_we = we; wb_waddr = a; wb_wdata = d; port_b_busy = busy; raddr_a = ra; raddr_b = rb;
    exp_cnt  = exp_q.size();
    prev_blk = (exp_cnt != 0) && busy;
    fwd_model(ra, exp_fa_v, exp_fa_d);
    fwd_model(rb, exp_fb_v, exp_fb_d);
    if (we && a != 5'd0) begin
      if (a[4:2] == 3'b011) exp_l1_q.push_back({a, d});
      else model_sram(a, d, busy);
    end
  endtask

  task automatic check_step();
    check("count", 64'(count), 64'(exp_cnt));
    check("ready", 64'(wb_ready), 64'(exp_cnt != DEPTH));
    check("stall", 64'(stall_req), 64'(starve >= LIMIT));
    check("fwd_a_valid", 64'(fwd_a_valid), 64'(exp_fa_v));
    check("fwd_b_valid", 64'(fwd_b_valid), 64'(exp_fb_v));
    if (exp_fa_v) check("fwd_a_data", 64'(fwd_a_data), 64'(exp_fa_d));
    if (exp_fb_v) check("fwd_b_data", 64'(fwd_b_data), 64'(exp_fb_d));
  endtask

  task automatic drain_all();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 32) begin
      step(1'b0, 5'd0, '0, 1'b0);
      #2 check_step();
      #3;
      k++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every RF write against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_got = {rf_waddr, rf_wdata};
      if (!rf_we) begin
        check("rf_idle_zero", 64'(mon_got), 64'd0);
      end else if (rf_waddr[4:2] == 3'b011) begin
        if (exp_l1_q.size() == 0) check("rf_l1_unexpected", 64'd1, 64'd0);
        else check("rf_l1_write", 64'(mon_got), 64'(exp_l1_q.pop_front()));
      end else begin
        if (exp_q.size() == 0) check("rf_sram_unexpected", 64'd1, 64'd0);
        else check("rf_sram_write", 64'(mon_got), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [4:0] addr_tbl [9];

  initial begin
    addr_tbl = '{5'd0, 5'd3, 5'd5, 5'd7, 5'd9, 5'd12, 5'd13, 5'd17, 5'd31};

    // Reset state
    #12;
    check("rst_ready", 64'(wb_ready), 64'd1);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Direct pass-through when empty and port B free
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    #2 check_step();
    check("pass_we", 64'(rf_we), 64'd1);
    check("pass_addr", 64'(rf_waddr), 64'd5);

    // Queue under busy, drain in order
    step(1'b1, 5'd5, 32'h11, 1'b1);
    step(1'b1, 5'd6, 32'h22, 1'b1);
    #2 check_step();
    step(1'b0, 5'd0, '0, 1'b0);
    #2 check_step();
    check("drain1_addr", 64'(rf_waddr), 64'd5);
    step(1'b0, 5'd0, '0, 1'b0);
    #2 check_step();
    check("drain2_addr", 64'(rf_waddr), 64'd6);
    step(1'b0, 5'd0, '0, 1'b0);
    #2 check_step();

    // Youngest-match forwarding, L1 bypass during busy
    step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 5'd7);
    step(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 5'd7);
    #2 check_step();
    step(1'b1, 5'd13, 32'h1313, 1'b1, 5'd7, 5'd7);
    #2 check_step();
    check("l1_we", 64'(rf_we), 64'd1);
    check("l1_addr", 64'(rf_waddr), 64'd13);
    check("fwd_youngest", 64'(fwd_a_data), 64'hB);
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7);
    #2 check_step();
    step(1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd7);
    #2 check_step();
    check("fwd_while_drain", 64'(fwd_a_valid), 64'd1);
    drain_all();

    // Write to x0 is dropped
    step(1'b1, 5'd0, 32'h55, 1'b0);
    #2 check_step();
    check("x0_dropped", 64'(rf_we), 64'd0);

    // Fill under busy, starvation stall
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 5'(i), 32'h100 + i, 1'b1);
      #2 check_step();
    end
    for (int i = 0; i < LIMIT; i++) begin
      step(1'b0, 5'd0, '0, 1'b1, 5'd2);
      #2 check_step();
    end
    check("full_ready", 64'(wb_ready), 64'd0);
    check("stall_set", 64'(stall_req), 64'd1);
    step(1'b0, 5'd0, '0, 1'b0);
    #2 check_step();
    step(1'b0, 5'd0, '0, 1'b0);
    #2 check_step();
    check("stall_clear", 64'(stall_req), 64'd0);
    drain_all();

    // Asynchronous reset mid-drain
    step(1'b1, 5'd20, 32'h20, 1'b1);
    step(1'b1, 5'd21, 32'h21, 1'b1);
    step(1'b1, 5'd22, 32'h22, 1'b1);
    step(1'b0, 5'd0, '0, 1'b0, 5'd21, 5'd22);
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_l1_q.delete();
    starve = 0;
    prev_blk = 0;
    #1;
    check("arst_rf_we", 64'(rf_we), 64'd0);
    check("arst_rf_bus", 64'({rf_waddr, rf_wdata}), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(wb_ready), 64'd1);
    check("arst_fwd", 64'({fwd_a_valid, fwd_b_valid}), 64'd0);
    check("arst_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b0, 5'd0, '0, 1'b0, 5'd21, 5'd22);
    #2 check_step();

`ifdef IBEX_RF_WBUF_COALESCE_EN
    // Coalescing of repeated writes to the same register
    step(1'b1, 5'd9, 32'd1, 1'b1);
    step(1'b1, 5'd9, 32'd2, 1'b1);
    step(1'b0, 5'd0, '0, 1'b1, 5'd9);
    #2 check_step();
    check("coal_count", 64'(count), 64'd1);
    drain_all();
`endif

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      logic          we, busy;
      logic [4:0]    a, ra, rb;
      busy = ($urandom_range(0, 99) < 50);
      we   = ($urandom_range(0, 3) != 0) && (exp_q.size() < DEPTH);
      a    = addr_tbl[$urandom_range(0, 8)];
      ra   = addr_tbl[$urandom_range(0, 8)];
      rb   = addr_tbl[$urandom_range(0, 8)];
      step(we, a, $urandom, busy, ra, rb);
      #2 check_step();
    end
    drain_all();
    check("l1_left", 64'(exp_l1_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
